// File: rtl/rgb_sbit2wrd_p.sv
// Serial-bit to LED-word assembler: collects decoded bits MSB first into
// BITS_PER_LED-bit words and forwards them to the LED FIFO through a small holding queue.
module rgb_sbit2wrd_p #(
  parameter int BITS_PER_LED = 24,
  parameter int OUT_W        = 32,
  parameter int HOLD_DEPTH   = 2,
  parameter int PARTIAL_MODE = 0,
  parameter int JUSTIFY      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_strobe,
  input  logic             in_sbit_value,
  input  logic             in_stream_reset,
  input  logic             no_room_at_the_fifo_inn,
  input  logic             clr_overflow,
  output logic [OUT_W-1:0] out_word,
  output logic             out_strobe,
  output logic             out_partial,
  output logic             need_a_manger,
  output logic [15:0]      words_dropped,
  output logic [5:0]       bit_count
);

  localparam int BPL = BITS_PER_LED;
  localparam logic [5:0] LAST_BIT = 6'(BPL - 1);
  localparam logic [5:0] BPL_W    = 6'(BPL);
  localparam logic [2:0] PTR_MASK = 3'(HOLD_DEPTH - 1);
  localparam logic [3:0] DEPTH    = 4'(HOLD_DEPTH);

  logic           strobe_d;
  logic           ev;
  logic [BPL-1:0] sh;
  logic [5:0]     bit_cnt;

  logic           push;
  logic [BPL-1:0] push_word;
  logic           push_part;

  logic [BPL:0]   q_mem [0:7];
  logic [2:0]     wr_ptr;
  logic [2:0]     rd_ptr;
  logic [3:0]     q_cnt;
  logic           q_full;
  logic           pop;
  logic           accept;
  logic           drop;
  logic [BPL-1:0] head_word;
  logic [OUT_W-1:0] head_placed;

  assign ev        = in_strobe & ~strobe_d;
  assign bit_count = bit_cnt;

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    push_part = 1'b0;
    if (ev) begin
      if (in_stream_reset) begin
        // sh holds bit_cnt bits right-aligned; shift them up to the MSBs
        if (bit_cnt != 6'd0 && PARTIAL_MODE == 1) begin
          push      = 1'b1;
          push_word = sh << (BPL_W - bit_cnt);
          push_part = 1'b1;
        end
      end else if (bit_cnt == LAST_BIT) begin
        push      = 1'b1;
        push_word = {sh[BPL-2:0], in_sbit_value};
      end
    end
  end

  assign q_full = (q_cnt == DEPTH);
  assign pop    = (q_cnt != 4'd0) && !no_room_at_the_fifo_inn;
  assign accept = push && (!q_full || pop);
  assign drop   = push && q_full && !pop;

  assign head_word = q_mem[rd_ptr][BPL:1];

  if (JUSTIFY == 1) begin : g_left
    assign head_placed = OUT_W'(head_word) << (OUT_W - BPL);
  end else begin : g_right
    assign head_placed = OUT_W'(head_word);
  end

  // strobe_d follows in_strobe even in reset, so a strobe already high at
  // reset release is seen as old and does not create an event.
  always_ff @(posedge clk) begin
    strobe_d <= in_strobe;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (ev) begin
      if (in_stream_reset || bit_cnt == LAST_BIT) begin
        sh      <= '0;
        bit_cnt <= '0;
      end else begin
        sh      <= {sh[BPL-2:0], in_sbit_value};
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept) q_mem[wr_ptr] <= {push_word, push_part};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_cnt       <= '0;
      out_word    <= '0;
      out_strobe  <= 1'b0;
      out_partial <= 1'b0;
    end else begin
      out_strobe <= pop;
      if (accept) wr_ptr <= (wr_ptr + 3'd1) & PTR_MASK;
      if (pop) begin
        rd_ptr      <= (rd_ptr + 3'd1) & PTR_MASK;
        out_word    <= head_placed;
        out_partial <= q_mem[rd_ptr][0];
      end
      case ({accept, pop})
        2'b10:   q_cnt <= q_cnt + 4'd1;
        2'b01:   q_cnt <= q_cnt - 4'd1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // A drop on the same edge as a clear leaves the flag set and a count of one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      need_a_manger <= 1'b0;
      words_dropped <= '0;
    end else if (drop) begin
      need_a_manger <= 1'b1;
      if (clr_overflow)                   words_dropped <= 16'd1;
      else if (words_dropped != 16'hFFFF) words_dropped <= words_dropped + 16'd1;
    end else if (clr_overflow) begin
      need_a_manger <= 1'b0;
      words_dropped <= '0;
    end
  end

endmodule

// File: tb/tb_rgb_sbit2wrd_p.sv
// Bench for rgb_sbit2wrd_p: four configurations share one stimulus stream,
// each with its own expected-word queue checked whenever it pulses out_strobe.
module tb_rgb_sbit2wrd_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_strobe = 1'b0;
  logic in_sbit_value = 1'b0;
  logic in_stream_reset = 1'b0;
  logic no_room = 1'b0;
  logic clr_overflow = 1'b0;

  logic [31:0] a_word, j_word, w_word, p_word;
  logic a_strobe, j_strobe, w_strobe, p_strobe;
  logic a_part, j_part, w_part, p_part;
  logic a_flag, j_flag, w_flag, p_flag;
  logic [15:0] a_drop, j_drop, w_drop, p_drop;
  logic [5:0] a_bc, j_bc, w_bc, p_bc;

  logic [32:0] exp_a[$];
  logic [32:0] exp_j[$];
  logic [32:0] exp_w[$];
  logic [32:0] exp_p[$];

  logic [3:0] mon_en = 4'b0000;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ev_cyc = 0;
  int a_strobes = 0;
  int a_last_cyc = 0;
  int a_prev_cyc = 0;

  always #5 clk = ~clk;

  rgb_sbit2wrd_p u_a (
    .clk(clk), .rst_n(rst_n), .in_strobe(in_strobe), .in_sbit_value(in_sbit_value),
    .in_stream_reset(in_stream_reset), .no_room_at_the_fifo_inn(no_room),
    .clr_overflow(clr_overflow), .out_word(a_word), .out_strobe(a_strobe),
    .out_partial(a_part), .need_a_manger(a_flag), .words_dropped(a_drop), .bit_count(a_bc));

  rgb_sbit2wrd_p #(.JUSTIFY(1)) u_j (
    .clk(clk), .rst_n(rst_n), .in_strobe(in_strobe), .in_sbit_value(in_sbit_value),
    .in_stream_reset(in_stream_reset), .no_room_at_the_fifo_inn(no_room),
    .clr_overflow(clr_overflow), .out_word(j_word), .out_strobe(j_strobe),
    .out_partial(j_part), .need_a_manger(j_flag), .words_dropped(j_drop), .bit_count(j_bc));

  rgb_sbit2wrd_p #(.BITS_PER_LED(32)) u_w (
    .clk(clk), .rst_n(rst_n), .in_strobe(in_strobe), .in_sbit_value(in_sbit_value),
    .in_stream_reset(in_stream_reset), .no_room_at_the_fifo_inn(no_room),
    .clr_overflow(clr_overflow), .out_word(w_word), .out_strobe(w_strobe),
    .out_partial(w_part), .need_a_manger(w_flag), .words_dropped(w_drop), .bit_count(w_bc));

  rgb_sbit2wrd_p #(.PARTIAL_MODE(1)) u_p (
    .clk(clk), .rst_n(rst_n), .in_strobe(in_strobe), .in_sbit_value(in_sbit_value),
    .in_stream_reset(in_stream_reset), .no_room_at_the_fifo_inn(no_room),
    .clr_overflow(clr_overflow), .out_word(p_word), .out_strobe(p_strobe),
    .out_partial(p_part), .need_a_manger(p_flag), .words_dropped(p_drop), .bit_count(p_bc));

  // One clock; outputs are sampled on the falling edge and matched against the queues.
  task automatic step();
    logic [32:0] e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mon_en[0] && a_strobe) begin
      a_strobes++;
      a_prev_cyc = a_last_cyc;
      a_last_cyc = cyc;
      n_cmp++;
      if (exp_a.size() == 0) begin
        n_err++;
        $display("FAIL a_unexpected: got %h, required no output", {a_part, a_word});
      end else begin
        e = exp_a.pop_front();
        if ({a_part, a_word} !== e) begin
          n_err++;
          $display("FAIL a_word: got %h, required %h", {a_part, a_word}, e);
        end
      end
    end
    if (mon_en[1] && j_strobe) begin
      n_cmp++;
      if (exp_j.size() == 0) begin
        n_err++;
        $display("FAIL j_unexpected: got %h, required no output", {j_part, j_word});
      end else begin
        e = exp_j.pop_front();
        if ({j_part, j_word} !== e) begin
          n_err++;
          $display("FAIL j_word: got %h, required %h", {j_part, j_word}, e);
        end
      end
    end
    if (mon_en[2] && w_strobe) begin
      n_cmp++;
      if (exp_w.size() == 0) begin
        n_err++;
        $display("FAIL w_unexpected: got %h, required no output", {w_part, w_word});
      end else begin
        e = exp_w.pop_front();
        if ({w_part, w_word} !== e) begin
          n_err++;
          $display("FAIL w_word: got %h, required %h", {w_part, w_word}, e);
        end
      end
    end
    if (mon_en[3] && p_strobe) begin
      n_cmp++;
      if (exp_p.size() == 0) begin
        n_err++;
        $display("FAIL p_unexpected: got %h, required no output", {p_part, p_word});
      end else begin
        e = exp_p.pop_front();
        if ({p_part, p_word} !== e) begin
          n_err++;
          $display("FAIL p_word: got %h, required %h", {p_part, p_word}, e);
        end
      end
    end
  endtask

  task automatic send_ev(input logic val, input logic sr, input int width);
    in_sbit_value   = val;
    in_stream_reset = sr;
    in_strobe       = 1'b1;
    step();
    last_ev_cyc = cyc;
    repeat (width - 1) step();
    in_strobe       = 1'b0;
    in_sbit_value   = 1'b0;
    in_stream_reset = 1'b0;
    step();
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits, input int width);
    for (int i = nbits - 1; i >= 0; i--) send_ev(w[i], 1'b0, width);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_strobe = 1'b0;
    in_sbit_value = 1'b0;
    in_stream_reset = 1'b0;
    no_room = 1'b0;
    clr_overflow = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_a.delete();
    exp_j.delete();
    exp_w.delete();
    exp_p.delete();
    a_strobes = 0;
  endtask

  task automatic test_reset();
    mon_en = 4'b0000;
    rst_n = 1'b0;
    in_strobe = 1'b1;
    step();
    step();
    n_cmp++; if (a_word !== 32'd0) begin n_err++; $display("FAIL rst_word: got %h, required 0", a_word); end
    n_cmp++; if (a_strobe !== 1'b0) begin n_err++; $display("FAIL rst_strobe: got %b, required 0", a_strobe); end
    n_cmp++; if (a_part !== 1'b0) begin n_err++; $display("FAIL rst_partial: got %b, required 0", a_part); end
    n_cmp++; if (a_flag !== 1'b0) begin n_err++; $display("FAIL rst_flag: got %b, required 0", a_flag); end
    n_cmp++; if (a_drop !== 16'd0) begin n_err++; $display("FAIL rst_dropped: got %0d, required 0", a_drop); end
    n_cmp++; if (a_bc !== 6'd0) begin n_err++; $display("FAIL rst_bit_count: got %0d, required 0", a_bc); end
    // strobe held high across reset release must not count as a bit
    rst_n = 1'b1;
    step();
    step();
    n_cmp++; if (a_bc !== 6'd0) begin n_err++; $display("FAIL rst_held_strobe: got %0d, required 0", a_bc); end
    in_strobe = 1'b0;
    step();
  endtask

  task automatic test_strobe_width();
    do_reset();
    mon_en = 4'b1001;
    send_ev(1'b0, 1'b0, 1);
    send_ev(1'b1, 1'b0, 2);
    send_ev(1'b0, 1'b0, 3);
    send_ev(1'b1, 1'b0, 4);
    n_cmp++; if (a_bc !== 6'd4) begin n_err++; $display("FAIL sw_bit_count: got %0d, required 4", a_bc); end
    n_cmp++; if (p_bc !== 6'd4) begin n_err++; $display("FAIL sw_p_bit_count: got %0d, required 4", p_bc); end
    // the partial flush exposes exactly the four shifted bits 0101
    exp_p.push_back({1'b1, 32'h0050_0000});
    send_ev(1'b0, 1'b1, 1);
    repeat (4) step();
    n_cmp++; if (exp_p.size() != 0) begin n_err++; $display("FAIL sw_missing: got %0d left, required 0", exp_p.size()); end
    n_cmp++; if (a_bc !== 6'd0) begin n_err++; $display("FAIL sw_cleared: got %0d, required 0", a_bc); end
  endtask

  task automatic test_full_word();
    logic [23:0] r;
    do_reset();
    mon_en = 4'b1011;
    exp_a.push_back({1'b0, 32'h00A5_C3F0});
    exp_j.push_back({1'b0, 32'hA5C3_F000});
    exp_p.push_back({1'b0, 32'h00A5_C3F0});
    send_word(32'h00A5_C3F0, 24, 2);
    n_cmp++; if (a_strobes != 1) begin n_err++; $display("FAIL fw_strobes: got %0d, required 1", a_strobes); end
    n_cmp++; if (a_last_cyc != last_ev_cyc + 1) begin n_err++; $display("FAIL fw_latency: got %0d, required %0d", a_last_cyc - last_ev_cyc, 1); end
    r = 24'($urandom);
    exp_a.push_back({1'b0, 8'h00, r});
    exp_j.push_back({1'b0, r, 8'h00});
    exp_p.push_back({1'b0, 8'h00, r});
    send_word({8'h00, r}, 24, 1);
    repeat (4) step();
    n_cmp++; if (exp_a.size() + exp_j.size() + exp_p.size() != 0) begin n_err++; $display("FAIL fw_missing: got %0d left, required 0", exp_a.size() + exp_j.size() + exp_p.size()); end
    n_cmp++; if (a_bc !== 6'd0) begin n_err++; $display("FAIL fw_bit_count: got %0d, required 0", a_bc); end
  endtask

  task automatic test_rgbw();
    logic [31:0] r;
    do_reset();
    mon_en = 4'b0100;
    exp_w.push_back({1'b0, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 32, 1);
    r = $urandom;
    exp_w.push_back({1'b0, r});
    send_word(r, 32, $urandom_range(1, 3));
    repeat (4) step();
    n_cmp++; if (exp_w.size() != 0) begin n_err++; $display("FAIL rgbw_missing: got %0d left, required 0", exp_w.size()); end
  endtask

  task automatic test_stream_reset();
    do_reset();
    mon_en = 4'b1001;
    send_ev(1'b1, 1'b1, 1);
    n_cmp++; if (a_bc !== 6'd0) begin n_err++; $display("FAIL sr_empty: got %0d, required 0", a_bc); end
    send_ev(1'b1, 1'b0, 1);
    n_cmp++; if (a_bc !== 6'd1) begin n_err++; $display("FAIL sr_one_bit: got %0d, required 1", a_bc); end
    exp_p.push_back({1'b1, 32'h0080_0000});
    send_ev(1'b0, 1'b1, 2);
    n_cmp++; if (a_bc !== 6'd0) begin n_err++; $display("FAIL sr_after_one: got %0d, required 0", a_bc); end
    for (int i = 0; i < 23; i++) send_ev((i % 2) == 0, 1'b0, 1);
    n_cmp++; if (a_bc !== 6'd23) begin n_err++; $display("FAIL sr_23_bits: got %0d, required 23", a_bc); end
    exp_p.push_back({1'b1, 32'h00AA_AAAA});
    send_ev(1'b1, 1'b1, 1);
    repeat (4) step();
    n_cmp++; if (exp_p.size() != 0) begin n_err++; $display("FAIL sr_missing: got %0d left, required 0", exp_p.size()); end
    n_cmp++; if (a_bc !== 6'd0 || p_bc !== 6'd0) begin n_err++; $display("FAIL sr_cleared: got %0d/%0d, required 0/0", a_bc, p_bc); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] w1, w2, w3, w4;
    do_reset();
    mon_en = 4'b0001;
    w1 = 24'($urandom);
    w2 = 24'($urandom);
    w3 = 24'($urandom);
    w4 = 24'($urandom);
    no_room = 1'b1;
    exp_a.push_back({1'b0, 8'h00, w1});
    exp_a.push_back({1'b0, 8'h00, w2});
    send_word({8'h00, w1}, 24, 1);
    send_word({8'h00, w2}, 24, 1);
    send_word({8'h00, w3}, 24, 1);
    n_cmp++; if (a_strobes != 0) begin n_err++; $display("FAIL bp_held: got %0d strobes, required 0", a_strobes); end
    n_cmp++; if (a_flag !== 1'b1) begin n_err++; $display("FAIL bp_flag: got %b, required 1", a_flag); end
    n_cmp++; if (a_drop !== 16'd1) begin n_err++; $display("FAIL bp_dropped: got %0d, required 1", a_drop); end
    // drop and clear on the same edge: the drop wins with a count of one
    send_word({9'h000, w4[23:1]}, 23, 1);
    in_sbit_value = w4[0];
    in_strobe = 1'b1;
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    in_strobe = 1'b0;
    step();
    n_cmp++; if (a_flag !== 1'b1 || a_drop !== 16'd1) begin n_err++; $display("FAIL bp_drop_clr: got %b/%0d, required 1/1", a_flag, a_drop); end
    no_room = 1'b0;
    repeat (4) step();
    n_cmp++; if (a_strobes != 2) begin n_err++; $display("FAIL bp_release: got %0d strobes, required 2", a_strobes); end
    n_cmp++; if (a_last_cyc - a_prev_cyc != 1) begin n_err++; $display("FAIL bp_consecutive: got gap %0d, required 1", a_last_cyc - a_prev_cyc); end
    n_cmp++; if (exp_a.size() != 0) begin n_err++; $display("FAIL bp_missing: got %0d left, required 0", exp_a.size()); end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    n_cmp++; if (a_flag !== 1'b0 || a_drop !== 16'd0) begin n_err++; $display("FAIL bp_clear: got %b/%0d, required 0/0", a_flag, a_drop); end
  endtask

  task automatic test_reset_mid_word();
    logic [23:0] r;
    do_reset();
    mon_en = 4'b0001;
    for (int i = 0; i < 10; i++) send_ev(1'b1, 1'b0, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (a_bc !== 6'd0) begin n_err++; $display("FAIL mid_bit_count: got %0d, required 0", a_bc); end
    r = 24'($urandom) & 24'h0F0F0F;
    exp_a.push_back({1'b0, 8'h00, r});
    send_word({8'h00, r}, 24, 1);
    repeat (4) step();
    n_cmp++; if (exp_a.size() != 0) begin n_err++; $display("FAIL mid_missing: got %0d left, required 0", exp_a.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_strobe_width();
    test_full_word();
    test_rgbw();
    test_stream_reset();
    test_back_to_back();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
